up_down_count_decoder: RTL

- Receiving end of a 2-bit up/down counter output bus: samples the counter's q value and decodes each transition into an up step, a down step, a hold or an illegal jump.
- Keeps a wide signed position, the last direction, and error statistics.
- Sits downstream of the 2-bit up/down counter. Used as a position tracker and as a self-checking monitor for it.

---
 rtl/up_down_count_decoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/up_down_count_decoder.sv
`default_nettype none
// ============================================================================
// Module      : up_down_count_decoder
// Description : Observes a 2-bit up/down counter bus. It decodes each sampled
//               transition into an up step, a down step, a hold or an illegal
//               jump, and tracks position, direction and error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module up_down_count_decoder #(
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       q_in,
    input  logic             q_valid,
    input  logic             clear,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam logic [POS_W-1:0] c_pos_one = 1;
    localparam logic [ERR_W-1:0] c_err_one = 1;
    localparam logic [ERR_W-1:0] c_err_max = {ERR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t             state_q,      state_d;
    logic [1:0]         q_ref_q,      q_ref_d;
    logic [POS_W-1:0]   pos_q,        pos_d;
    logic [ERR_W-1:0]   err_count_q,  err_count_d;
    logic               dir_q,        dir_d;
    logic               up_pulse_q,   up_pulse_d;
    logic               down_pulse_q, down_pulse_d;
    logic               err_pulse_q,  err_pulse_d;
    logic               err_sticky_q, err_sticky_d;
    logic               locked_q,     locked_d;

    // Two-bit subtraction wraps naturally, giving the step distance mod 4.
    logic [1:0] w_delta;
    assign w_delta = q_in - q_ref_q;

    always_comb begin
        state_d      = state_q;
        q_ref_d      = q_ref_q;
        pos_d        = pos_q;
        err_count_d  = err_count_q;
        dir_d        = dir_q;
        err_sticky_d = err_sticky_q;
        locked_d     = locked_q;
        up_pulse_d   = 1'b0;
        down_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;

        if (clear) begin
            pos_d        = '0;
            err_count_d  = '0;
            err_sticky_d = 1'b0;
            locked_d     = 1'b0;
            state_d      = ST_UNLOCKED;
        end else if (q_valid) begin
            q_ref_d = q_in;
            case (state_q)
                ST_UNLOCKED: begin
                    locked_d = 1'b1;
                    state_d  = ST_LOCKED;
                end
                ST_LOCKED: begin
                    case (w_delta)
                        2'd1: begin
                            up_pulse_d = 1'b1;
                            pos_d      = pos_q + c_pos_one;
                            dir_d      = 1'b1;
                        end
                        2'd3: begin
                            down_pulse_d = 1'b1;
                            pos_d        = pos_q - c_pos_one;
                            dir_d        = 1'b0;
                        end
                        2'd2: begin
                            err_pulse_d  = 1'b1;
                            err_sticky_d = 1'b1;
                            if (err_count_q != c_err_max) begin
                                err_count_d = err_count_q + c_err_one;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_UNLOCKED;
            q_ref_q      <= '0;
            pos_q        <= '0;
            err_count_q  <= '0;
            dir_q        <= 1'b0;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_ref_q      <= q_ref_d;
            pos_q        <= pos_d;
            err_count_q  <= err_count_d;
            dir_q        <= dir_d;
            up_pulse_q   <= up_pulse_d;
            down_pulse_q <= down_pulse_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            locked_q     <= locked_d;
        end
    end

    assign up_pulse   = up_pulse_q;
    assign down_pulse = down_pulse_q;
    assign err_pulse  = err_pulse_q;
    assign dir        = dir_q;
    assign pos        = pos_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign locked     = locked_q;

endmodule
`default_nettype wire
